// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit: byte-addressed requests to word memory via RMW (optional MEM_LSU_MISALIGNED_EN)
module mem_lsu #(
    parameter int RAM_SIZE_LOG = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_mode,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [RAM_SIZE_LOG-1:0] mem_addr,
    input  logic [31:0]             mem_rdata,
    output logic                    mem_we,
    output logic [31:0]             mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_RESP
    } state_t;

    localparam logic [2:0] MODE_BYTE  = 3'b000;
    localparam logic [2:0] MODE_HALF  = 3'b001;
    localparam logic [2:0] MODE_WORD  = 3'b010;
    localparam logic [2:0] MODE_UBYTE = 3'b100;
    localparam logic [2:0] MODE_UHALF = 3'b101;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              mode_q, mode_d;
    logic [1:0]              off_q, off_d;
    logic [RAM_SIZE_LOG-1:0] w0_q, w0_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             lo_q, lo_d;
    logic [31:0]             hi_q, hi_d;
    logic                    err_q, err_d;
    logic                    two_q, two_d;

    // Address bits above the word index alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:RAM_SIZE_LOG+2];

    logic [2:0] req_size;
    logic       req_illegal;
    logic       req_misal;
    logic       req_two;
    logic       req_err;
    logic       req_store_word;

    // Decode the incoming request: access size, legality, alignment and span.
    always_comb begin
        case (req_mode[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_illegal    = (req_mode == 3'b011) || (req_mode[2:1] == 2'b11);
        req_misal      = ((req_mode[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_mode[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_two        = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
`ifdef MEM_LSU_MISALIGNED_EN
        req_err        = req_illegal || (req_we && req_mode[2]);
`else
        req_err        = req_illegal || (req_we && req_mode[2]) || req_misal;
`endif
        req_store_word = req_we && (req_mode == MODE_WORD) && (req_addr[1:0] == 2'b00);
    end

    logic [RAM_SIZE_LOG-1:0] w1;
    logic [5:0]              shamt;
    logic [31:0]             mask32;
    logic [63:0]             mask64;
    logic [63:0]             data64;
    logic [63:0]             merged;
    logic [63:0]             shifted;
    logic [31:0]             load_val;

    // Lane handling over the {hi,lo} window: store merge and load extraction.
    always_comb begin
        w1     = w0_q + {{(RAM_SIZE_LOG-1){1'b0}}, 1'b1};
        shamt  = {1'b0, off_q, 3'b000};
        case (mode_q[1:0])
            2'b00:   mask32 = 32'h0000_00FF;
            2'b01:   mask32 = 32'h0000_FFFF;
            default: mask32 = 32'hFFFF_FFFF;
        endcase
        mask64  = {32'h0, mask32} << shamt;
        data64  = {32'h0, wdata_q} << shamt;
        merged  = ({hi_q, lo_q} & ~mask64) | (data64 & mask64);
        shifted = {hi_q, lo_q} >> shamt;
        case (mode_q)
            MODE_BYTE:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            MODE_HALF:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            MODE_WORD:  load_val = shifted[31:0];
            MODE_UBYTE: load_val = {24'h0, shifted[7:0]};
            MODE_UHALF: load_val = {16'h0, shifted[15:0]};
            default:    load_val = 32'h0;
        endcase
    end

    // State and request registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            mode_q  <= 3'b000;
            off_q   <= 2'b00;
            w0_q    <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            err_q   <= 1'b0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            w0_q    <= w0_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            two_q   <= two_d;
        end
    end

    // Next-state and output logic; outputs are forced quiet while reset is high.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        mode_d     = mode_q;
        off_d      = off_q;
        w0_d       = w0_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        err_d      = err_q;
        two_d      = two_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = 32'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    mode_d  = req_mode;
                    off_d   = req_addr[1:0];
                    w0_d    = req_addr[RAM_SIZE_LOG+1:2];
                    wdata_d = req_wdata;
                    lo_d    = 32'h0;
                    hi_d    = 32'h0;
                    err_d   = req_err;
`ifdef MEM_LSU_MISALIGNED_EN
                    two_d   = req_two && !req_err;
`else
                    two_d   = 1'b0;
`endif
                    if (req_err)             state_d = S_RESP;
                    else if (req_store_word) state_d = S_WR0;
                    else                     state_d = S_RD0;
                end
            end
            S_RD0: begin
                mem_addr = w0_q;
                lo_d     = mem_rdata;
                if (two_q)     state_d = S_RD1;
                else if (we_q) state_d = S_WR0;
                else           state_d = S_RESP;
            end
            S_RD1: begin
                mem_addr = w1;
                hi_d     = mem_rdata;
                state_d  = we_q ? S_WR0 : S_RESP;
            end
            S_WR0: begin
                mem_we    = 1'b1;
                mem_addr  = w0_q;
                mem_wdata = merged[31:0];
                state_d   = two_q ? S_WR1 : S_RESP;
            end
            S_WR1: begin
                mem_we    = 1'b1;
                mem_addr  = w1;
                mem_wdata = merged[63:32];
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'h0 : load_val;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = 32'h0;
            resp_err   = 1'b0;
            mem_addr   = '0;
            mem_we     = 1'b0;
            mem_wdata  = 32'h0;
        end
    end

    // The request decode also computes a span that only matters with the split feature.
    logic unused_two;
    assign unused_two = req_two;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu against a byte-addressed memory model
module tb_mem_lsu;

    localparam int RSL   = 8;
    localparam int WORDS = 1 << RSL;
    localparam int BYTES = WORDS * 4;
`ifdef MEM_LSU_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_we    = 1'b0;
    logic [2:0]     req_mode  = 3'b000;
    logic [31:0]    req_addr  = 32'h0;
    logic [31:0]    req_wdata = 32'h0;
    logic           req_ready;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic [RSL-1:0] mem_addr;
    logic [31:0]    mem_rdata;
    logic           mem_we;
    logic [31:0]    mem_wdata;

    logic [31:0] dmem    [WORDS];
    logic [31:0] ref_mem [WORDS];

    mem_lsu #(.RAM_SIZE_LOG(RSL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_we) dmem[mem_addr] = mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    bit          exp_active = 1'b0;
    bit          done       = 1'b0;
    int          cyc, exp_lat, exp_writes, we_cnt, got_lat;
    logic [31:0] exp_rdata, got_rdata;
    logic        exp_err, got_err;

    // Per-cycle compare against the expectation armed by the driver.
    always @(negedge clk) begin
        if (exp_active) begin
            cyc++;
            if (mem_we) we_cnt++;
            chk("ready_low_busy", {31'h0, req_ready}, 32'h0);
            if (resp_valid) begin
                got_lat   = cyc;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                chk("latency", cyc, exp_lat);
                chk("rdata", resp_rdata, exp_rdata);
                chk("err", {31'h0, resp_err}, {31'h0, exp_err});
                exp_active = 1'b0;
                done       = 1'b1;
            end else if (cyc > exp_lat) begin
                chk("resp_timeout", cyc, exp_lat);
                got_lat    = -1;
                exp_active = 1'b0;
                done       = 1'b1;
            end
        end else begin
            chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("idle_mem_we", {31'h0, mem_we}, 32'h0);
        end
    end

    function automatic logic [7:0] ref_byte(input int ba);
        return ref_mem[ba / 4][8*(ba % 4) +: 8];
    endfunction

    // Reference: byte-addressed view of memory, wrapping at the top.
    task automatic model(input bit we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int writes);
        int  size, off, ba0, b;
        bit  illegal, mis, two;
        logic [31:0] v;
        illegal = (mode == 3'd3) || (mode == 3'd6) || (mode == 3'd7);
        case (mode)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        off = int'(addr[1:0]);
        ba0 = int'(addr[9:0]);
        mis = (size == 2 && addr[0]) || (size == 4 && off != 0);
        two = (off + size) > 4;
        err = illegal || (we && mode[2]) || (!MIS && mis);
        rdata  = 32'h0;
        lat    = 1;
        writes = 0;
        if (err) return;
        if (!we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_byte((ba0 + i) % BYTES);
            if (mode == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (mode == 3'd1) v = {{16{v[15]}}, v[15:0]};
            rdata = v;
            lat   = two ? 3 : 2;
        end else begin
            for (int i = 0; i < size; i++) begin
                b = (ba0 + i) % BYTES;
                ref_mem[b / 4][8*(b % 4) +: 8] = wdata[8*i +: 8];
            end
            if (size == 4 && off == 0) begin
                lat = 2; writes = 1;
            end else begin
                lat = two ? 5 : 3; writes = two ? 2 : 1;
            end
        end
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        dmem[w]    = v;
        ref_mem[w] = v;
    endtask

    task automatic check_mem(input string name);
        int mism = 0;
        for (int w = 0; w < WORDS; w++) if (dmem[w] !== ref_mem[w]) mism++;
        chk(name, mism, 0);
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_req(input bit we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic        e;
        logic [31:0] r;
        int          l, wr;
        model(we, mode, addr, wdata, e, r, l, wr);
        wait_ready();
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        exp_err    = e;
        exp_rdata  = r;
        exp_lat    = l;
        exp_writes = wr;
        cyc        = 0;
        we_cnt     = 0;
        done       = 1'b0;
        exp_active = 1'b1;
        for (int k = 0; k < 20 && !done; k++) @(posedge clk);
        chk("writes", we_cnt, exp_writes);
        check_mem("mem_image");
    endtask

    // Abandon a sub-word store by reset after `hold` cycles in flight.
    task automatic reset_during(input int hold, input logic [31:0] addr);
        wait_ready();
        req_we    = 1'b1;
        req_mode  = 3'b001;
        req_addr  = addr;
        req_wdata = $urandom;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
        check_mem("mem_after_abort");
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) poke(w, $urandom);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        poke(2, 32'h1234_5680);
        do_req(1'b0, 3'b000, 32'h0000_0008, 32'h0);
        chk("lit_lb", got_rdata, 32'hFFFF_FF80);
        chk("lit_lb_lat", got_lat, 2);
        do_req(1'b0, 3'b100, 32'h0000_0008, 32'h0);
        chk("lit_lbu", got_rdata, 32'h0000_0080);

        poke(1, 32'h1122_3344);
        do_req(1'b1, 3'b001, 32'h0000_0006, 32'hAAAA_BEEF);
        chk("lit_sh_word", dmem[1], 32'hBEEF_3344);
        chk("lit_sh_we", we_cnt, 1);
        chk("lit_sh_lat", got_lat, 3);
        chk("lit_sh_err", {31'h0, got_err}, 32'h0);

        do_req(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D);
        chk("lit_sw_word", dmem[4], 32'hCAFE_F00D);
        chk("lit_sw_lat", got_lat, 2);

        do_req(1'b1, 3'b100, 32'h0000_0020, 32'h1234_5678);
        chk("lit_sbu_err", {31'h0, got_err}, 32'h1);
        chk("lit_sbu_lat", got_lat, 1);
        chk("lit_sbu_we", we_cnt, 0);

`ifdef MEM_LSU_MISALIGNED_EN
        poke(0, 32'h4433_2211);
        poke(1, 32'h8877_6655);
        do_req(1'b0, 3'b010, 32'h0000_0003, 32'h0);
        chk("lit_lw_mis", got_rdata, 32'h7766_5544);
        chk("lit_lw_mis_lat", got_lat, 3);
        poke(WORDS - 1, 32'h1111_2222);
        poke(0, 32'h3333_4444);
        do_req(1'b1, 3'b010, (WORDS - 1) * 4 + 2, 32'hDDCC_BBAA);
        chk("lit_sw_wrap_hi", dmem[WORDS - 1], 32'hBBAA_2222);
        chk("lit_sw_wrap_lo", dmem[0], 32'h3333_DDCC);
        chk("lit_sw_wrap_lat", got_lat, 5);
`else
        do_req(1'b1, 3'b001, 32'h0000_0003, 32'h5555_6666);
        chk("lit_sh_mis_err", {31'h0, got_err}, 32'h1);
        chk("lit_sh_mis_we", we_cnt, 0);
        do_req(1'b0, 3'b010, 32'h0000_0003, 32'h0);
        chk("lit_lw_mis_err", {31'h0, got_err}, 32'h1);
        chk("lit_lw_mis_rdata", got_rdata, 32'h0);
`endif

        reset_during(0, 32'h0000_0044);
        do_req(1'b0, 3'b010, 32'h0000_0044, 32'h0);
        reset_during(1, 32'h0000_0052);
        do_req(1'b0, 3'b101, 32'h0000_0052, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[9:2] = 8'hFF;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
